display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Owns the shared 4-digit 7-segment display and multiplexes it between two sources:
//  the scrolling-text menu word and the in-game display word. Selects the source from
//  the game state, snapshots it once per frame to avoid tearing, and scans the digits
//  with a dead-time guard. Blanks for a programmable number of frames after any change of presente.
// PARAMETERS
//  SCAN_DIV      50000  clk cycles per digit dwell (>= 4*GUARD_CYC+4)
//  GUARD_CYC     16     dead-time cycles at start of each dwell, anodes off
//  BLANK_FRAMES  4      full frames forced dark after a presente change (0 = none)
//  COMMON_ANODE  1      1: seg/an active-low; 0: active-high
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  presente      in   3   game state: OFF=0 WLCM=1 CH=2 GAME=3 WL=4 PA=5
//  display_menu  in   28  menu word; digit k = bits[7k+6:7k]
//  display_game  in   28  game word, same packing
//  seg           out  7   segment drive, bit0 = seg a
//  an            out  4   anode drive; digit k -> an[3-k] (digit 0 leftmost)
//  src_sel       out  1   0 = menu source, 1 = game source
//  frame_tick    out  1   1-cycle pulse when digit 3 dwell ends (frame wrap)
// BEHAVIOUR
//  - Reset: seg, an at inactive level (CA: 7'h7F/4'hF); src_sel=0; frame_tick=0;
//    state=IDLE; dwell cnt=0; digit idx=0; blank cnt=0; snapshot=0; prev_state=OFF.
//  - Source: presente==GAME -> game, else menu. src_sel registered, 1 cycle after presente.
//  - Dwell counter 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps, idx=(idx+1) mod 4; on 3->0 wrap
//    frame_tick=1 for that cycle and the selected word loads into the snapshot.
//  - Drive: an[3-idx] active only when cnt>=GUARD_CYC and state==SCAN; seg = snapshot
//    digit idx (inverted if COMMON_ANODE); else seg/an inactive. All outputs registered.
//  - FSM:
//    IDLE : presente==OFF; counters held 0, outputs inactive. presente!=OFF -> BLANK.
//    BLANK: counters run, outputs inactive; after BLANK_FRAMES frame_ticks -> SCAN
//           (BLANK_FRAMES=0: go to SCAN with first snapshot taken on entry).
//    SCAN : normal scanning.
//    Any state: presente!=prev_state -> cnt=0, idx=0, blank cnt=0, snapshot reloaded;
//      to IDLE if presente==OFF, else BLANK. prev_state updates every cycle.
//  - Entry to BLANK/SCAN from IDLE also loads the snapshot immediately.
//  - Simultaneous presente change and frame wrap: change wins, frame_tick suppressed.
//  - Source data changes mid-frame: ignored until next frame_tick.
//  - Illegal presente (6,7): menu source, treated as a normal state.
//  - rst mid-operation: all regs to reset values on that edge, outputs dark next cycle.
// CONFIGURATION
//  DISP_DIM_PAUSE_EN defined: while presente==PA and state==SCAN, anode active only for
//    cnt in [GUARD_CYC, GUARD_CYC+SCAN_DIV/4); seg inactive outside that window.
//  Not defined: PA uses full dwell like every other state; no extra logic.
// TESTING  (SCAN_DIV=8, GUARD_CYC=1, BLANK_FRAMES=1, COMMON_ANODE=1 unless stated)
//  1. rst=1 for 2 cycles, presente=0 -> seg=7'h7F, an=4'hF, frame_tick=0, src_sel=0 held.
//  2. presente 0->1, display_menu[6:0]=7'd118 -> dark for 32 cycles (1 frame); then
//     an=4'b0111, seg=7'h09 for 7 cycles after 1 guard cycle; next digit an=4'b1011.
//  3. presente=3, change display_game mid-frame -> src_sel=1 after 1 cycle; new value
//     appears only in the frame after the next frame_tick; frame_tick period = 32 cycles.
//  4. presente 3->4 on the frame-wrap cycle -> no frame_tick, cnt/idx=0, src_sel=0,
//     dark for 32 cycles, then menu snapshot scanned.
//  5. presente ->0 mid-dwell -> next cycle an=4'hF, seg=7'h7F; stays dark; counters 0.
//  6. DISP_DIM_PAUSE_EN, presente=5, after blank -> each digit active only at cnt=1,2
//     (2 of 8 cycles); same stimulus without the macro -> cnt=1..7 active.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Bus bundle between the display scan controller and its data sources / display pins.
// The master side supplies game state and both source words; the slave side drives the display.
interface display_scan_ctrl_if;
    logic [2:0]  presente;
    logic [27:0] display_menu;
    logic [27:0] display_game;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        src_sel;
    logic        frame_tick;

    modport master (
        output presente, display_menu, display_game,
        input  seg, an, src_sel, frame_tick
    );

    modport slave (
        input  presente, display_menu, display_game,
        output seg, an, src_sel, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Shared 4-digit 7-segment scanner: picks menu or game word, snapshots it once per frame,
// scans with a dead-time guard and blanks after game-state changes. Optional: DISP_DIM_PAUSE_EN.
module display_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYC    = 16,
    parameter int BLANK_FRAMES = 4,
    parameter int COMMON_ANODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_ctrl_if.slave   bus
);
    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int BLANK_W = $clog2(BLANK_FRAMES + 1) + 1;

    localparam logic [2:0] ST_OFF  = 3'd0;
    localparam logic [2:0] ST_GAME = 3'd3;

    localparam logic [6:0]       SEG_OFF   = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0]       AN_OFF    = (COMMON_ANODE != 0) ? 4'hF : 4'h0;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYC);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [BLANK_W-1:0] BLANK_ZERO = {BLANK_W{1'b0}};

`ifdef DISP_DIM_PAUSE_EN
    localparam logic [2:0]       ST_PA       = 3'd5;
    localparam logic [CNT_W-1:0] CNT_DIM_END = CNT_W'(GUARD_CYC + SCAN_DIV / 4);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SCAN  = 2'd2
    } state_t;

    // With no blanking requested, a state change goes straight to scanning.
    localparam state_t ENTRY_ST = (BLANK_FRAMES == 0) ? SCAN : BLANK;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, adv_cnt_s;
    logic [1:0]         idx_r, idx_s, adv_idx_s;
    logic [BLANK_W-1:0] blank_r, blank_s, blank_inc_s;
    logic [27:0]        snap_r, snap_s, sel_word_s;
    logic [2:0]         prev_r;
    logic [6:0]         seg_r, seg_s;
    logic [3:0]         an_r, an_s;
    logic               src_r, tick_r, tick_s;
    logic               change_s, wrap_s, frame_wrap_s, lit_s;

    function automatic logic [6:0] digit_drive(input logic [27:0] word, input logic [1:0] k);
        logic [6:0] d;
        case (k)
            2'd0:    d = word[6:0];
            2'd1:    d = word[13:7];
            2'd2:    d = word[20:14];
            default: d = word[27:21];
        endcase
        return (COMMON_ANODE != 0) ? ~d : d;
    endfunction

    // Digit 0 is the leftmost position, wired to the top anode bit.
    function automatic logic [3:0] anode_drive(input logic [1:0] k);
        logic [3:0] a;
        case (k)
            2'd0:    a = 4'b1000;
            2'd1:    a = 4'b0100;
            2'd2:    a = 4'b0010;
            default: a = 4'b0001;
        endcase
        return (COMMON_ANODE != 0) ? ~a : a;
    endfunction

    // Next-state, counters, snapshot and next output values.
    always_comb begin
        sel_word_s   = (bus.presente == ST_GAME) ? bus.display_game : bus.display_menu;
        change_s     = (bus.presente != prev_r);
        wrap_s       = (state_r != IDLE) && (cnt_r == CNT_LAST);
        frame_wrap_s = wrap_s && (idx_r == 2'd3);
        adv_cnt_s    = wrap_s ? CNT_ZERO : (cnt_r + CNT_W'(1));
        adv_idx_s    = wrap_s ? (idx_r + 2'd1) : idx_r;
        blank_inc_s  = blank_r + BLANK_W'(1);

        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        blank_s = blank_r;
        snap_s  = snap_r;
        tick_s  = 1'b0;

        // A state change restarts the frame and wins over a coincident wrap.
        if (change_s) begin
            cnt_s   = CNT_ZERO;
            idx_s   = 2'd0;
            blank_s = BLANK_ZERO;
            snap_s  = sel_word_s;
            state_s = (bus.presente == ST_OFF) ? IDLE : ENTRY_ST;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_s   = CNT_ZERO;
                    idx_s   = 2'd0;
                    blank_s = BLANK_ZERO;
                    if (bus.presente != ST_OFF) begin
                        state_s = ENTRY_ST;
                        snap_s  = sel_word_s;
                    end else begin
                        state_s = IDLE;
                    end
                end
                BLANK: begin
                    cnt_s = adv_cnt_s;
                    idx_s = adv_idx_s;
                    if (frame_wrap_s) begin
                        tick_s = 1'b1;
                        snap_s = sel_word_s;
                        if (blank_inc_s >= BLANK_W'(BLANK_FRAMES)) begin
                            state_s = SCAN;
                            blank_s = BLANK_ZERO;
                        end else begin
                            blank_s = blank_inc_s;
                        end
                    end else begin
                        blank_s = blank_r;
                    end
                end
                SCAN: begin
                    cnt_s = adv_cnt_s;
                    idx_s = adv_idx_s;
                    if (frame_wrap_s) begin
                        tick_s = 1'b1;
                        snap_s = sel_word_s;
                    end else begin
                        snap_s = snap_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                    idx_s   = 2'd0;
                    blank_s = BLANK_ZERO;
                end
            endcase
        end

        lit_s = (state_s == SCAN) && (cnt_s >= CNT_GUARD);
`ifdef DISP_DIM_PAUSE_EN
        if ((bus.presente == ST_PA) && (cnt_s >= CNT_DIM_END)) begin
            lit_s = 1'b0;
        end else begin
            lit_s = lit_s;
        end
`endif
        seg_s = lit_s ? digit_drive(snap_s, idx_s) : SEG_OFF;
        an_s  = lit_s ? anode_drive(idx_s) : AN_OFF;
    end

    // State, counters, snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 2'd0;
            blank_r <= BLANK_ZERO;
            snap_r  <= 28'd0;
            prev_r  <= ST_OFF;
            seg_r   <= SEG_OFF;
            an_r    <= AN_OFF;
            src_r   <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            blank_r <= blank_s;
            snap_r  <= snap_s;
            prev_r  <= bus.presente;
            seg_r   <= seg_s;
            an_r    <= an_s;
            src_r   <= (bus.presente == ST_GAME);
            tick_r  <= tick_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.an         = an_r;
    assign bus.src_sel    = src_r;
    assign bus.frame_tick = tick_r;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios with literal expectations,
// then random traffic compared every cycle against a phase-arithmetic reference model.
module tb_display_scan_ctrl;
    localparam int SD    = 8;
    localparam int G     = 1;
    localparam int BF    = 1;
    localparam int FRAME = 4 * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    display_scan_ctrl_if dif ();

    display_scan_ctrl #(
        .SCAN_DIV(SD), .GUARD_CYC(G), .BLANK_FRAMES(BF), .COMMON_ANODE(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    // Reference model: phase = cycles since the last game-state change.
    int          m_p     = 0;
    logic        m_act   = 1'b0;
    logic [2:0]  m_prev  = 3'd0;
    logic [27:0] m_snap  = 28'd0;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_src, e_tick;
    bit          m_valid = 1'b0;

    task automatic model_step();
        int   cnt, idx;
        logic lit, dim_ok;
        logic [27:0] sel;
        sel = (dif.presente == 3'd3) ? dif.display_game : dif.display_menu;
        if (rst) begin
            m_p = 0; m_act = 1'b0; m_prev = 3'd0; m_snap = 28'd0;
            e_src = 1'b0; e_tick = 1'b0;
        end else begin
            e_src = (dif.presente == 3'd3);
            if (dif.presente != m_prev) begin
                m_prev = dif.presente; m_p = 0; m_act = (dif.presente != 3'd0);
                m_snap = sel; e_tick = 1'b0;
            end else if (m_act) begin
                m_p++;
                e_tick = (m_p % FRAME == 0);
                if (e_tick) m_snap = sel;
            end else begin
                e_tick = 1'b0;
            end
        end
        cnt = m_p % SD;
        idx = (m_p / SD) % 4;
`ifdef DISP_DIM_PAUSE_EN
        dim_ok = (m_prev != 3'd5) || (cnt < G + SD / 4);
`else
        dim_ok = 1'b1;
`endif
        lit   = m_act && (m_p / FRAME >= BF) && (cnt >= G) && dim_ok;
        e_an  = lit ? ~(4'b1000 >> idx) : 4'hF;
        e_seg = lit ? ~m_snap[7*idx +: 7] : 7'h7F;
        m_valid = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_p(input int target);
        int n = 0;
        @(negedge clk);
        while (m_p != target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (m_p != target) begin
            total++; bad++;
            $display("FAIL wait_phase: phase %0d got %0d want %0d", target, m_p, target);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("seg", {25'd0, dif.seg}, {25'd0, e_seg});
            chk("an", {28'd0, dif.an}, {28'd0, e_an});
            chk("src_sel", {31'd0, dif.src_sel}, {31'd0, e_src});
            chk("frame_tick", {31'd0, dif.frame_tick}, {31'd0, e_tick});
        end
    end

    initial begin
        dif.presente = 3'd0;
        dif.display_menu = 28'd0;
        dif.display_game = 28'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_seg", {25'd0, dif.seg}, 32'h7F);
        chk("rst_an", {28'd0, dif.an}, 32'hF);
        chk("rst_tick", {31'd0, dif.frame_tick}, 32'd0);
        chk("rst_src", {31'd0, dif.src_sel}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_an", {28'd0, dif.an}, 32'hF);

        // Menu after one blank frame.
        dif.display_menu = {7'h11, 7'h22, 7'h3F, 7'd118};
        dif.presente = 3'd1;
        wait_p(31);
        chk("blank_an", {28'd0, dif.an}, 32'hF);
        wait_p(32);
        chk("blank_end_tick", {31'd0, dif.frame_tick}, 32'd1);
        chk("guard_an", {28'd0, dif.an}, 32'hF);
        wait_p(33);
        chk("d0_an", {28'd0, dif.an}, 32'h7);
        chk("d0_seg", {25'd0, dif.seg}, 32'h09);
        wait_p(41);
        chk("d1_an", {28'd0, dif.an}, 32'hB);
        chk("d1_seg", {25'd0, dif.seg}, 32'h40);

        // Game source, word changed mid-frame.
        dif.display_game = {7'h00, 7'h00, 7'h5B, 7'h06};
        dif.presente = 3'd3;
        @(negedge clk);
        chk("src_game", {31'd0, dif.src_sel}, 32'd1);
        wait_p(40);
        dif.display_game = {7'h00, 7'h00, 7'h66, 7'h4F};
        wait_p(41);
        chk("old_snap", {25'd0, dif.seg}, 32'h24);
        wait_p(63);
        chk("no_tick", {31'd0, dif.frame_tick}, 32'd0);
        wait_p(64);
        chk("tick_period", {31'd0, dif.frame_tick}, 32'd1);
        wait_p(65);
        chk("new_snap", {25'd0, dif.seg}, 32'h30);
        wait_p(73);
        chk("new_snap_d1", {25'd0, dif.seg}, 32'h19);

        // Change exactly on the frame wrap.
        wait_p(95);
        dif.presente = 3'd4;
        @(negedge clk);
        chk("wrap_chg_tick", {31'd0, dif.frame_tick}, 32'd0);
        chk("wrap_chg_an", {28'd0, dif.an}, 32'hF);
        chk("wrap_chg_src", {31'd0, dif.src_sel}, 32'd0);
        wait_p(33);
        chk("wl_seg", {25'd0, dif.seg}, 32'h09);

        // Off mid-dwell.
        wait_p(37);
        dif.presente = 3'd0;
        @(negedge clk);
        chk("off_an", {28'd0, dif.an}, 32'hF);
        chk("off_seg", {25'd0, dif.seg}, 32'h7F);
        repeat (5) @(negedge clk);
        chk("off_stay", {28'd0, dif.an}, 32'hF);

        // Pause state window.
        dif.presente = 3'd5;
        wait_p(33);
        chk("pa_cnt1", {28'd0, dif.an}, 32'h7);
        wait_p(34);
        chk("pa_cnt2", {28'd0, dif.an}, 32'h7);
        wait_p(35);
`ifdef DISP_DIM_PAUSE_EN
        chk("pa_cnt3", {28'd0, dif.an}, 32'hF);
`else
        chk("pa_cnt3", {28'd0, dif.an}, 32'h7);
`endif

        // Random traffic including illegal states and reset.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) dif.presente = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) dif.display_menu = 28'($urandom);
            if ($urandom_range(0, 9) == 0) dif.display_game = 28'($urandom);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
